// File: rtl/mult_unit.sv
// Iterative shift-add multiplier for mult/multu: one partial-product step per
// cycle, WIDTH steps, then a one-cycle DONE with the 2*WIDTH-bit product in Hi/Lo.
module mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MultStart,
   input  logic             MultSigned,
   input  logic             Cancel,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             ProdV,
   output logic             Busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] mcand;
   logic             neg;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     step_hi;
   logic [WIDTH-1:0]   step_lo;
   logic [2*WIDTH-1:0] prod, result;

   // Signed operands are reduced to magnitudes; the most negative value maps to itself.
   assign mag_a = (MultSigned && SrcA[WIDTH-1]) ? -SrcA : SrcA;
   assign mag_b = (MultSigned && SrcB[WIDTH-1]) ? -SrcB : SrcB;

   always_comb begin
      sum     = acc_hi + {1'b0, (acc_lo[0] ? mcand : '0)};
      step_hi = {1'b0, sum[WIDTH:1]};
      step_lo = {sum[0], acc_lo[WIDTH-1:1]};
      prod    = {step_hi[WIDTH-1:0], step_lo};
      result  = neg ? -prod : prod;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         mcand  <= '0;
         neg    <= 1'b0;
         Hi     <= '0;
         Lo     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (MultStart && !Cancel) begin
                  state  <= BUSY;
                  count  <= CW'(WIDTH-1);
                  acc_hi <= '0;
                  acc_lo <= mag_b;
                  mcand  <= mag_a;
                  neg    <= MultSigned & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
               end
            end
            BUSY: begin
               if (Cancel) begin
                  state <= IDLE;
               end else begin
                  acc_hi <= step_hi;
                  acc_lo <= step_lo;
                  count  <= count - 1'b1;
                  if (count == '0) begin
                     state    <= DONE;
                     {Hi, Lo} <= result;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign ProdV = (state == DONE);
   assign Busy  = (state != IDLE);

endmodule

// File: tb/tb_mult_unit.sv
// Randomized self-checking bench for mult_unit against a plain 64-bit arithmetic model.
module tb_mult_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        MultStart, MultSigned, Cancel;
   logic [31:0] SrcA, SrcB;
   logic [31:0] Hi, Lo;
   logic        ProdV, Busy;

   int vectors = 0;
   int miscompares = 0;
   logic [63:0] last_prod = '0;

   mult_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .MultStart(MultStart), .MultSigned(MultSigned),
      .Cancel(Cancel), .SrcA(SrcA), .SrcB(SrcB), .Hi(Hi), .Lo(Lo),
      .ProdV(ProdV), .Busy(Busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      return 64'(sa * sb);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts an operation at the next edge (t0) and checks the full timeline to t0+33.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit scramble, input string tag);
      logic [63:0] exp;
      exp = ref_prod(a, b, s);
      SrcA = a; SrcB = b; MultSigned = s; MultStart = 1'b1;
      tick();
      MultStart = 1'b0;
      chk({tag, ".busy_t0"}, 64'(Busy), 64'd1);
      for (int k = 1; k < 32; k++) begin
         if (scramble) begin
            SrcA = $urandom; SrcB = $urandom; MultSigned = 1'($urandom);
         end
         tick();
         chk({tag, ".busy"}, 64'({Busy, ProdV}), 64'b10);
      end
      tick();
      chk({tag, ".prodv"}, 64'({Busy, ProdV}), 64'b11);
      chk({tag, ".prod"}, {Hi, Lo}, exp);
      tick();
      chk({tag, ".idle"}, 64'({Busy, ProdV}), 64'b00);
      chk({tag, ".hold"}, {Hi, Lo}, exp);
      last_prod = exp;
   endtask

   initial begin
      logic [31:0] a, b;
      int          t;
      reset = 1'b1; MultStart = 0; MultSigned = 0; Cancel = 0; SrcA = 0; SrcB = 0;
      #12;
      chk("reset.out", {Hi, Lo}, 64'd0);
      chk("reset.flags", 64'({Busy, ProdV}), 64'b00);
      reset = 1'b0;
      tick();

      run_op(32'd3, 32'd5, 1'b0, 0, "multu3x5");
      chk("multu3x5.lo", 64'(Lo), 64'hF);
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, "multu_max");
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, "mult_m1");
      run_op(32'hFFFFFFFF, 32'h2, 1'b1, 0, "mult_m1x2");
      run_op(32'h80000000, 32'h80000000, 1'b1, 0, "mult_min");
      run_op(32'd7, 32'd9, 1'b0, 1, "scramble");

      // Cancel seen at edge t0+11 aborts 2x2 with no ProdV and Hi/Lo kept.
      SrcA = 2; SrcB = 2; MultSigned = 0; MultStart = 1'b1;
      tick();
      MultStart = 1'b0;
      for (int k = 1; k <= 10; k++) tick();
      Cancel = 1'b1;
      tick();
      Cancel = 1'b0;
      chk("cancel.idle", 64'(Busy), 64'd0);
      t = 0;
      for (int k = 0; k < 36; k++) begin
         tick();
         if (ProdV) t++;
      end
      chk("cancel.noprodv", 64'(t), 64'd0);
      chk("cancel.keep", {Hi, Lo}, last_prod);

      // Cancel coincident with a start request: no start.
      SrcA = 5; SrcB = 5; MultStart = 1'b1; Cancel = 1'b1;
      tick();
      MultStart = 1'b0; Cancel = 1'b0;
      chk("cancel_start.idle", 64'(Busy), 64'd0);

      // Asynchronous reset in the middle of an operation.
      SrcA = 11; SrcB = 13; MultStart = 1'b1;
      tick();
      MultStart = 1'b0;
      for (int k = 1; k <= 5; k++) tick();
      #2 reset = 1'b1;
      #1;
      chk("areset.out", {Hi, Lo}, 64'd0);
      chk("areset.flags", 64'({Busy, ProdV}), 64'b00);
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("areset.stay", 64'(Busy), 64'd0);

      // Held request: 4x4, operands switched to 6x6 during DONE, restart after IDLE cycle.
      SrcA = 4; SrcB = 4; MultSigned = 0; MultStart = 1'b1;
      tick();
      for (int k = 1; k <= 32; k++) tick();
      chk("b2b.prodv1", 64'(ProdV), 64'd1);
      chk("b2b.lo1", {Hi, Lo}, 64'h10);
      SrcA = 6; SrcB = 6;
      tick();
      chk("b2b.gap", 64'({Busy, ProdV}), 64'b00);
      tick();
      chk("b2b.t0", 64'(Busy), 64'd1);
      MultStart = 1'b0;
      t = -1;
      for (int k = 1; k <= 40 && t < 0; k++) begin
         tick();
         if (ProdV) t = k;
      end
      chk("b2b.lat2", 64'(t), 64'd32);
      chk("b2b.lo2", {Hi, Lo}, 64'h24);
      tick();

      // Random operations, with the occasional corner operand.
      for (int i = 0; i < 40; i++) begin
         a = $urandom; b = $urandom;
         case ($urandom_range(0, 5))
            0: a = 32'h80000000;
            1: b = 32'hFFFFFFFF;
            2: a = 0;
            default: ;
         endcase
         run_op(a, b, 1'($urandom), 1'($urandom_range(0, 3) == 0), "rand");
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
